// File: rtl/key_pkg.sv
// Shared types and default timing constants for the multi-key LED controller.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } key_fsm_e;

    localparam int unsigned DEF_DB_CNT   = 32'd1_000_000;
    localparam int unsigned DEF_LONG_CNT = 32'd50_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM and long-press hold counter.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DB_CNT   = DEF_DB_CNT,
    parameter int unsigned LONG_CNT = DEF_LONG_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state,
    output logic long_flag,
    output logic toggle_req
);

    localparam int unsigned DB_W   = $clog2(DB_CNT);
    localparam int unsigned LONG_W = $clog2(LONG_CNT);
    // The FSM state itself supplies one stable sample, so the filter counter stops at DB_CNT-2.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 2);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

    logic              sync1_r, sync2_r;
    key_fsm_e          state_r, state_s;
    logic [DB_W-1:0]   db_cnt_r, db_cnt_s;
    logic [LONG_W-1:0] hold_r, hold_s;
    logic              key_flag_r, key_flag_s;
    logic              key_state_r, key_state_s;
    logic              long_flag_r, long_flag_s;
    logic              run_hold_s;
    logic              toggle_s;

    // Next-state, counter and flag decisions for the channel FSM.
    always_comb begin
        state_s     = state_r;
        db_cnt_s    = db_cnt_r;
        hold_s      = hold_r;
        key_flag_s  = 1'b0;
        key_state_s = key_state_r;
        long_flag_s = 1'b0;
        run_hold_s  = 1'b0;
        toggle_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!sync2_r) begin
                    state_s  = PRESS_FILT;
                    db_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_FILT: begin
                if (sync2_r) begin
                    state_s = IDLE;
                end else if (db_cnt_r == DB_LAST) begin
                    state_s     = DOWN;
                    key_state_s = 1'b0;
                    key_flag_s  = 1'b1;
                    hold_s      = '0;
                end else begin
                    db_cnt_s = db_cnt_r + DB_W'(1);
                end
            end
            DOWN: begin
                run_hold_s = 1'b1;
                if (sync2_r) begin
                    state_s  = REL_FILT;
                    db_cnt_s = '0;
                end else begin
                    state_s = DOWN;
                end
            end
            REL_FILT: begin
                if (!sync2_r) begin
                    state_s    = DOWN;
                    run_hold_s = 1'b1;
                end else if (db_cnt_r == DB_LAST) begin
                    state_s     = IDLE;
                    key_state_s = 1'b1;
                    key_flag_s  = 1'b1;
                    toggle_s    = (hold_r != LONG_LAST);
                end else begin
                    db_cnt_s   = db_cnt_r + DB_W'(1);
                    run_hold_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Saturating hold counter; the long pulse fires only on the step into LONG_LAST.
        if (run_hold_s && (hold_r != LONG_LAST)) begin
            hold_s      = hold_r + LONG_W'(1);
            long_flag_s = (hold_s == LONG_LAST);
        end else begin
            long_flag_s = 1'b0;
        end
    end

    // Synchroniser, FSM state, counters and registered flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r     <= 1'b1;
            sync2_r     <= 1'b1;
            state_r     <= IDLE;
            db_cnt_r    <= '0;
            hold_r      <= '0;
            key_flag_r  <= 1'b0;
            key_state_r <= 1'b1;
            long_flag_r <= 1'b0;
        end else begin
            sync1_r     <= key_in;
            sync2_r     <= sync1_r;
            state_r     <= state_s;
            db_cnt_r    <= db_cnt_s;
            hold_r      <= hold_s;
            key_flag_r  <= key_flag_s;
            key_state_r <= key_state_s;
            long_flag_r <= long_flag_s;
        end
    end

    assign key_flag   = key_flag_r;
    assign key_state  = key_state_r;
    assign long_flag  = long_flag_r;
    assign toggle_req = toggle_s;

endmodule

// File: rtl/multi_key_led_ctrl.sv
// N independent debounced keys; a short press toggles its LED, a long press on any key clears all LEDs.
module multi_key_led_ctrl
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS   = 4,
    parameter int unsigned DB_CNT   = DEF_DB_CNT,
    parameter int unsigned LONG_CNT = DEF_LONG_CNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_flag,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] long_flag,
    output logic [N_KEYS-1:0] led
);

    logic [N_KEYS-1:0] toggle_req_s;
    logic [N_KEYS-1:0] led_r, led_s;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CNT   (DB_CNT),
            .LONG_CNT (LONG_CNT)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .key_in     (key_in[i]),
            .key_flag   (key_flag[i]),
            .key_state  (key_state[i]),
            .long_flag  (long_flag[i]),
            .toggle_req (toggle_req_s[i])
        );
    end

    // Clear-all from a registered long pulse takes priority over any toggle in the same cycle.
    always_comb begin
        led_s = led_r;
        if (|long_flag) begin
            led_s = '0;
        end else begin
            led_s = led_r ^ toggle_req_s;
        end
    end

    // LED register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_r <= '0;
        end else begin
            led_r <= led_s;
        end
    end

    assign led = led_r;

endmodule
